mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single 8-bit, 20-bit-address memory bus between the CPU core and one DMA requester
//  (video fetch or block copy). The memory is synchronous: read data is valid one cycle after the
//  address is presented. The CPU is stalled through a clock-enable while DMA owns the bus; DMA
//  ownership is bounded so the core is never starved.
// PARAMETERS
//  AW         20  address width
//  DW          8  data width
//  DMA_BURST   4  max consecutive DMA cycles before a forced CPU slot (1..15)
// PORTS
//  clock        in   1   system clock, all logic on posedge
//  reset        in   1   synchronous, active-high
//  cpu_address  in   AW  core address
//  cpu_out      in   DW  core write data
//  cpu_wren     in   1   core write enable
//  cpu_lock     in   1   core forbids preemption (multi-byte sequence in progress)
//  cpu_ce       out  1   core clock-enable; 0 = core must hold all state
//  cpu_data     out  DW  read data to core (= mem_data, passthrough)
//  dma_req      in   1   DMA wants a bus cycle (level, held until ack)
//  dma_addr     in   AW  DMA address
//  dma_wdata    in   DW  DMA write data
//  dma_we       in   1   DMA write
//  dma_ack      out  1   DMA cycle accepted this clock (address/write taken)
//  dma_rvalid   out  1   dma_rdata valid (one cycle after a read ack)
//  dma_rdata    out  DW  DMA read data
//  mem_address  out  AW  to RAM
//  mem_out      out  DW  to RAM write data
//  mem_wren     out  1   to RAM write enable
//  mem_data     in   DW  from RAM, valid one cycle after mem_address
// BEHAVIOUR
//  States: S_CPU, S_DMA, S_RESTORE (registered). Bus mux is combinational from the state.
//  S_CPU:     mem_* = cpu_*; cpu_ce=1; dma_ack=0.
//             next = S_DMA if dma_req & !cpu_lock, else S_CPU. The current CPU cycle always completes.
//  S_DMA:     mem_* = dma_*; mem_wren = dma_we & dma_req; cpu_ce=0; dma_ack = dma_req.
//             burst counter increments on each ack; cleared on leaving S_DMA.
//             next = S_RESTORE if !dma_req or the count reaches DMA_BURST, else S_DMA.
//  S_RESTORE: mem_address=cpu_address, mem_wren=0, cpu_ce=0, dma_ack=0; re-primes the read
//             data for the core's held address. next = S_CPU unconditionally
//             (at least one CPU cycle is guaranteed even if dma_req is still high).
//  dma_rvalid: registered; 1 the cycle after an ack with dma_we=0; dma_rdata = mem_data in that cycle.
//  A DMA write is committed in its ack cycle; dma_rvalid stays 0 for writes.
//  cpu_wren is ignored (mem_wren not driven from it) whenever cpu_ce=0.
//  A cpu_lock rise in the same cycle as dma_req: lock wins, stay in S_CPU.
//  A dma_req drop in S_DMA: no ack that cycle, mem_wren=0, go to S_RESTORE.
//  Reset: state <= S_RESTORE, counter <= 0, dma_rvalid <= 0. During reset, and in the first cycle
//   after it, cpu_ce=0, dma_ack=0 and mem_wren=0. The first CPU cycle is the 2nd clock after reset deassert.
//  Reset mid-DMA abandons the cycle; no rvalid follows. The requester re-issues.
//  Worst-case CPU stall per preemption: DMA_BURST+1 cycles.
// STRUCTURE
//  Shared package/include (mem_bus_defs.v): state encodings S_CPU=2'd0, S_DMA=2'd1,
//   S_RESTORE=2'd2; AW/DW defaults.
//  Single flat module; the burst counter is inline. No sub-module.
// TESTING
//  1 Reset held 3 clocks, then released -> cpu_ce=0 for one clock, then 1; mem_wren=0 throughout.
//  2 dma_req read of 0x12345 while idle CPU reads 0x00100 -> 1 CPU cycle, ack for 1 cycle at 0x12345,
//    rvalid next clock with the RAM byte, 1 RESTORE cycle at 0x00100, then cpu_ce=1.
//  3 dma_req held continuously, DMA_BURST=4 -> repeating pattern of 4 acks, RESTORE, CPU.
//    cpu_ce duty is 1 of 6 clocks.
//  4 cpu_lock=1 with dma_req=1 for 10 clocks -> no ack, cpu_ce=1 every clock.
//    Lock drop -> S_DMA on the next clock.
//  5 DMA write 0xA5 to 0x00200, then a CPU read of 0x00200 -> core sees 0xA5.
//    A cpu_wren held during the stall writes nothing.
//  6 reset asserted during S_DMA -> dma_ack=0 and no rvalid on the following clock; state is S_RESTORE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the CPU/DMA memory bus arbiter:
//   - state_t        : arbiter ownership states (S_CPU, S_DMA, S_RESTORE)
//   - AW_DEFAULT     : default address width
//   - DW_DEFAULT     : default data width
//   - BURST_DEFAULT  : default maximum consecutive DMA acks
//   - CNT_W          : width of the burst counter (holds 0..15)
//   - burst_last()   : true when the ack about to be taken is the last of a burst
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam int unsigned AW_DEFAULT    = 20;
    localparam int unsigned DW_DEFAULT    = 8;
    localparam int unsigned BURST_DEFAULT = 4;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        S_CPU     = 2'd0,
        S_DMA     = 2'd1,
        S_RESTORE = 2'd2
    } state_t;

    // cnt is the number of acks already taken in this DMA tenure.
    function automatic logic burst_last(input logic [CNT_W-1:0] cnt, input int unsigned burst);
        int unsigned taken;
        taken = {{(32-CNT_W){1'b0}}, cnt} + 32'd1;
        return (taken >= burst);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one synchronous memory bus between the CPU core and a single DMA
// requester. The core is stalled through a clock-enable while DMA owns the bus;
// a DMA tenure is capped at DMA_BURST acks, followed by a restore cycle that
// re-primes the read data for the core's held address, then at least one CPU cycle.
//
// Ports
//   i_clock        system clock (posedge)
//   i_reset        synchronous active-high reset
//   i_cpu_address  core address
//   i_cpu_out      core write data
//   i_cpu_wren     core write enable (ignored while o_cpu_ce=0)
//   i_cpu_lock     core forbids preemption
//   o_cpu_ce       core clock-enable
//   o_cpu_data     read data to core (passthrough of i_mem_data)
//   i_dma_req      DMA request level, held until acked
//   i_dma_addr     DMA address
//   i_dma_wdata    DMA write data
//   i_dma_we       DMA write
//   o_dma_ack      DMA cycle accepted this clock
//   o_dma_rvalid   o_dma_rdata valid (cycle after a read ack)
//   o_dma_rdata    DMA read data (passthrough of i_mem_data)
//   o_mem_address  RAM address
//   o_mem_out      RAM write data
//   o_mem_wren     RAM write enable
//   i_mem_data     RAM read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW        = AW_DEFAULT,
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned DMA_BURST = BURST_DEFAULT
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [AW-1:0] i_cpu_address,
    input  logic [DW-1:0] i_cpu_out,
    input  logic          i_cpu_wren,
    input  logic          i_cpu_lock,
    output logic          o_cpu_ce,
    output logic [DW-1:0] o_cpu_data,
    input  logic          i_dma_req,
    input  logic [AW-1:0] i_dma_addr,
    input  logic [DW-1:0] i_dma_wdata,
    input  logic          i_dma_we,
    output logic          o_dma_ack,
    output logic          o_dma_rvalid,
    output logic [DW-1:0] o_dma_rdata,
    output logic [AW-1:0] o_mem_address,
    output logic [DW-1:0] o_mem_out,
    output logic          o_mem_wren,
    input  logic [DW-1:0] i_mem_data
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rvalid;

    logic [AW-1:0]    w_mem_address;
    logic [DW-1:0]    w_mem_out;
    logic             w_mem_wren;
    logic             w_cpu_ce;
    logic             w_dma_ack;

    // Bus mux, combinational from the registered state. Reset gates every
    // strobe so nothing is written or acknowledged while reset is held.
    always_comb begin
        w_mem_address = i_cpu_address;
        w_mem_out     = i_cpu_out;
        w_mem_wren    = 1'b0;
        w_cpu_ce      = 1'b0;
        w_dma_ack     = 1'b0;
        case (r_state)
            S_CPU: begin
                w_cpu_ce   = 1'b1;
                w_mem_wren = i_cpu_wren;
            end
            S_DMA: begin
                w_mem_address = i_dma_addr;
                w_mem_out     = i_dma_wdata;
                w_mem_wren    = i_dma_we & i_dma_req;
                w_dma_ack     = i_dma_req;
            end
            default: begin
                // S_RESTORE (and any illegal code): present the core's address
                // so its read data is valid again when the core resumes.
                w_mem_address = i_cpu_address;
            end
        endcase
        if (i_reset) begin
            w_mem_wren = 1'b0;
            w_cpu_ce   = 1'b0;
            w_dma_ack  = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_RESTORE;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_dma_ack & ~i_dma_we;
            case (r_state)
                S_CPU: begin
                    r_cnt <= '0;
                    // Lock wins over a simultaneous request.
                    if (i_dma_req && !i_cpu_lock) begin
                        r_state <= S_DMA;
                    end
                end
                S_DMA: begin
                    if (!i_dma_req || burst_last(r_cnt, DMA_BURST)) begin
                        r_state <= S_RESTORE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESTORE: begin
                    r_state <= S_CPU;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_RESTORE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_mem_address = w_mem_address;
    assign o_mem_out     = w_mem_out;
    assign o_mem_wren    = w_mem_wren;
    assign o_cpu_ce      = w_cpu_ce;
    assign o_dma_ack     = w_dma_ack;
    assign o_dma_rvalid  = r_rvalid;
    assign o_cpu_data    = i_mem_data;
    assign o_dma_rdata   = i_mem_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios followed by randomized traffic. A bus-ownership model
// (who owns each cycle, how many acks taken so far) predicts every output;
// a golden memory tracks the writes the model expects so read data is
// predicted independently of the RAM the DUT actually drives.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 8;
    localparam int unsigned BURST = 4;
    localparam int unsigned MEMSZ = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_out;
    logic          cpu_wren;
    logic          cpu_lock;
    logic          cpu_ce;
    logic [DW-1:0] cpu_data;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_we;
    logic          dma_ack;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_out;
    logic          mem_wren;
    logic [DW-1:0] mem_data = '0;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .DMA_BURST (BURST)
    ) dut (
        .i_clock       (clk),
        .i_reset       (reset),
        .i_cpu_address (cpu_address),
        .i_cpu_out     (cpu_out),
        .i_cpu_wren    (cpu_wren),
        .i_cpu_lock    (cpu_lock),
        .o_cpu_ce      (cpu_ce),
        .o_cpu_data    (cpu_data),
        .i_dma_req     (dma_req),
        .i_dma_addr    (dma_addr),
        .i_dma_wdata   (dma_wdata),
        .i_dma_we      (dma_we),
        .o_dma_ack     (dma_ack),
        .o_dma_rvalid  (dma_rvalid),
        .o_dma_rdata   (dma_rdata),
        .o_mem_address (mem_address),
        .o_mem_out     (mem_out),
        .o_mem_wren    (mem_wren),
        .i_mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    // Physical synchronous RAM driven by the DUT (read-first).
    logic [DW-1:0] ram    [MEMSZ];
    logic [DW-1:0] golden [MEMSZ];

    function automatic int unsigned idx(input logic [AW-1:0] a);
        return int'(a) % MEMSZ;
    endfunction

    always @(posedge clk) begin
        mem_data <= ram[idx(mem_address)];
        if (mem_wren) ram[idx(mem_address)] <= mem_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 = core owns the cycle, 1 = DMA owns it, 2 = hand-back gap
    int            owner    = 2;
    int            acks     = 0;
    logic          rv_exp   = 1'b0;
    logic [AW-1:0] rv_addr  = '0;
    logic [DW-1:0] exp_rd   = '0;
    logic          rd_known = 1'b0;
    logic          last_ack = 1'b0;

    always @(negedge clk) begin
        logic          ce_e, ack_e, wren_e;
        logic [AW-1:0] addr_e;
        logic [DW-1:0] out_e;
        ce_e = 0; ack_e = 0; wren_e = 0; addr_e = cpu_address; out_e = cpu_out;
        if (owner == 0) begin
            ce_e = 1; wren_e = cpu_wren;
        end else if (owner == 1) begin
            addr_e = dma_addr; out_e = dma_wdata; ack_e = dma_req; wren_e = dma_req & dma_we;
        end
        if (reset) begin
            ce_e = 0; ack_e = 0; wren_e = 0;
        end

        if (rd_known) chk("cpu_data", {24'd0, cpu_data}, {24'd0, exp_rd});
        chk("rvalid", {31'd0, dma_rvalid}, {31'd0, rv_exp});
        if (rv_exp) chk("rdata", {24'd0, dma_rdata}, {24'd0, exp_rd});
        chk("cpu_ce", {31'd0, cpu_ce}, {31'd0, ce_e});
        chk("dma_ack", {31'd0, dma_ack}, {31'd0, ack_e});
        chk("mem_wren", {31'd0, mem_wren}, {31'd0, wren_e});
        if (!reset) chk("mem_address", {12'd0, mem_address}, {12'd0, addr_e});
        if (wren_e) chk("mem_out", {24'd0, mem_out}, {24'd0, out_e});

        last_ack = dma_ack;
        rv_exp   = ack_e & ~dma_we;
        rd_known = !reset;
        if (!reset) begin
            exp_rd = golden[idx(addr_e)];
            if (wren_e) golden[idx(addr_e)] = out_e;
        end

        if (reset) begin
            owner = 2; acks = 0;
        end else if (owner == 0) begin
            if (dma_req && !cpu_lock) begin
                owner = 1; acks = 0;
            end
        end else if (owner == 1) begin
            if (dma_req) acks++;
            if (!dma_req || acks == BURST) begin
                owner = 2; acks = 0;
            end
        end else begin
            owner = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        int ce_cnt;
        int ack_cnt;
        bit got;

        for (int i = 0; i < MEMSZ; i++) begin
            ram[i]    = DW'($urandom);
            golden[i] = ram[i];
        end
        ram[idx(20'h12345)] = 8'h5C;
        golden[idx(20'h12345)] = 8'h5C;

        reset = 1; cpu_address = '0; cpu_out = '0; cpu_wren = 0; cpu_lock = 0;
        dma_req = 0; dma_addr = '0; dma_wdata = '0; dma_we = 0;

        // 1: reset for three clocks, then one dead cycle, then the core runs
        repeat (3) begin
            look();
            chk("t1 ce in reset", {31'd0, cpu_ce}, 32'd0);
            chk("t1 wren in reset", {31'd0, mem_wren}, 32'd0);
            cyc();
        end
        reset = 0; cpu_address = 20'h00100;
        look();
        chk("t1 ce first", {31'd0, cpu_ce}, 32'd0);
        chk("t1 wren first", {31'd0, mem_wren}, 32'd0);
        cyc();
        look();
        chk("t1 ce second", {31'd0, cpu_ce}, 32'd1);

        // 2: single DMA read while the core idles on 0x00100
        cyc();
        dma_req = 1; dma_addr = 20'h12345; dma_we = 0;
        look();
        chk("t2 cpu slot ce", {31'd0, cpu_ce}, 32'd1);
        chk("t2 cpu slot ack", {31'd0, dma_ack}, 32'd0);
        cyc();
        look();
        chk("t2 ack", {31'd0, dma_ack}, 32'd1);
        chk("t2 ack addr", {12'd0, mem_address}, 32'h12345);
        cyc();
        dma_req = 0;
        look();
        chk("t2 rvalid", {31'd0, dma_rvalid}, 32'd1);
        chk("t2 rdata", {24'd0, dma_rdata}, 32'h5C);
        cyc();
        look();
        chk("t2 restore ce", {31'd0, cpu_ce}, 32'd0);
        chk("t2 restore addr", {12'd0, mem_address}, 32'h00100);
        cyc();
        look();
        chk("t2 resume ce", {31'd0, cpu_ce}, 32'd1);

        // 3: continuous request, four periods of CPU + 4 acks + restore
        cyc();
        dma_req = 1; dma_addr = 20'h00040;
        ce_cnt = 0; ack_cnt = 0;
        repeat (24) begin
            look();
            ce_cnt  += int'(cpu_ce);
            ack_cnt += int'(dma_ack);
            cyc();
        end
        chk("t3 ce duty", ce_cnt, 32'd4);
        chk("t3 acks", ack_cnt, 32'd16);

        // 4: lock holds off a pending request
        dma_req = 0;
        repeat (3) cyc();
        dma_req = 1; cpu_lock = 1;
        ce_cnt = 0; ack_cnt = 0;
        repeat (10) begin
            look();
            ce_cnt  += int'(cpu_ce);
            ack_cnt += int'(dma_ack);
            cyc();
        end
        chk("t4 ce locked", ce_cnt, 32'd10);
        chk("t4 acks locked", ack_cnt, 32'd0);
        cpu_lock = 0;
        look();
        chk("t4 drop ce", {31'd0, cpu_ce}, 32'd1);
        cyc();
        look();
        chk("t4 ack after drop", {31'd0, dma_ack}, 32'd1);
        cyc();
        dma_req = 0;
        repeat (3) cyc();

        // 5: DMA write then CPU read of the same byte; stalled cpu_wren is inert
        cpu_address = 20'h00200; cpu_wren = 0;
        dma_req = 1; dma_addr = 20'h00200; dma_wdata = 8'hA5; dma_we = 1;
        look();
        chk("t5 cpu slot ce", {31'd0, cpu_ce}, 32'd1);
        cyc();
        cpu_wren = 1; cpu_out = 8'h3C;
        look();
        chk("t5 ack", {31'd0, dma_ack}, 32'd1);
        chk("t5 wr data", {24'd0, mem_out}, 32'hA5);
        cyc();
        dma_req = 0; dma_we = 0;
        look();
        chk("t5 stalled wren", {31'd0, mem_wren}, 32'd0);
        chk("t5 no rvalid", {31'd0, dma_rvalid}, 32'd0);
        cyc();
        look();
        chk("t5 restore wren", {31'd0, mem_wren}, 32'd0);
        cyc();
        cpu_wren = 0;
        look();
        chk("t5 resume ce", {31'd0, cpu_ce}, 32'd1);
        chk("t5 core read", {24'd0, cpu_data}, 32'hA5);

        // 6: reset in the middle of a DMA tenure
        cyc();
        dma_req = 1; dma_addr = 20'h00333; dma_we = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            look();
            if (dma_ack) got = 1;
            else cyc();
        end
        chk("t6 ack seen", {31'd0, got}, 32'd1);
        cyc();
        reset = 1;
        look();
        chk("t6 ack in reset", {31'd0, dma_ack}, 32'd0);
        chk("t6 ce in reset", {31'd0, cpu_ce}, 32'd0);
        cyc();
        reset = 0;
        look();
        chk("t6 no rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("t6 restore ack", {31'd0, dma_ack}, 32'd0);
        chk("t6 restore ce", {31'd0, cpu_ce}, 32'd0);
        cyc();
        look();
        chk("t6 resume ce", {31'd0, cpu_ce}, 32'd1);
        cyc();
        dma_req = 0;

        // randomized traffic, requester holds each request until acked
        repeat (3000) begin
            cyc();
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) cpu_lock = ~cpu_lock;
            cpu_address = AW'($urandom);
            cpu_out     = DW'($urandom);
            cpu_wren    = ($urandom_range(0, 3) == 0);
            if (dma_req && !last_ack) begin
                // hold current request
            end else if (!dma_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0))
                begin
                dma_req   = 1;
                dma_addr  = AW'($urandom);
                dma_wdata = DW'($urandom);
                dma_we    = ($urandom_range(0, 2) == 0);
            end else begin
                dma_req = 0;
            end
        end
        cyc();
        look();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
